// File: rtl/sram_pkg.sv
// ============================================================================
// Module  : sram_pkg
// Purpose : Shared state encoding, control-bus layout and control decode for
//           the external asynchronous SRAM controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_WHOLD = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int CE = 4;
   localparam int OE = 3;
   localparam int WE = 2;
   localparam int UB = 1;
   localparam int LB = 0;

   localparam logic [4:0] CTRL_IDLE = 5'b11111;

   // Active-low control bus value presented while the FSM sits in state s.
   function automatic logic [4:0] ctrl_for(input state_t s, input logic [1:0] be);
      logic [4:0] c;
      c = CTRL_IDLE;
      case (s)
         S_READ: begin
            c[CE] = 1'b0;
            c[OE] = 1'b0;
            c[UB] = ~be[1];
            c[LB] = ~be[0];
         end
         S_WRITE: begin
            c[CE] = 1'b0;
            c[WE] = 1'b0;
            c[UB] = ~be[1];
            c[LB] = ~be[0];
         end
         S_WHOLD: begin
            c[CE] = 1'b0;
            c[UB] = ~be[1];
            c[LB] = ~be[0];
         end
         default: c = CTRL_IDLE;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module  : sram_wait_counter
// Purpose : 4-bit load/decrement wait-state counter with a zero flag; it
//           saturates at zero rather than wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 4'd0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != 4'd0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module  : sram_controller
// Purpose : Converts single-word CPU load/store requests into timed accesses
//           on an external asynchronous SRAM with programmable wait states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller
   import sram_pkg::*;
#(
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 16,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_be,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [4:0]        sram_ctrl,
   inout  wire  [DATA_W-1:0] sram_dq
);

   localparam int         HALF      = DATA_W / 2;
   localparam logic [3:0] C_RD_LOAD = 4'(RD_WAIT - 1);
   localparam logic [3:0] C_WR_LOAD = 4'(WR_WAIT - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_be;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [4:0]          r_ctrl;
   logic                r_drive_en;

   logic                w_accept;
   logic                w_sample;
   logic                w_cnt_load;
   logic [3:0]          w_cnt_load_val;
   logic                w_cnt_dec;
   logic                w_cnt_zero;
   logic [1:0]          w_be_next;
   logic [DATA_W-1:0]   w_rdata_masked;

   sram_wait_counter u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (w_cnt_load),
      .load_val (w_cnt_load_val),
      .dec      (w_cnt_dec),
      .zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_accept       = 1'b0;
      w_sample       = 1'b0;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (cpu_req) begin
               w_accept = 1'b1;
               if (cpu_be == 2'b00) begin
                  w_state_next = S_DONE;
               end else if (!cpu_we) begin
                  w_state_next   = S_READ;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = C_RD_LOAD;
               end else begin
                  w_state_next   = S_WRITE;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = C_WR_LOAD;
               end
            end
         end
         S_READ: begin
            if (w_cnt_zero) begin
               w_sample     = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_WRITE: begin
            if (w_cnt_zero) begin
               w_state_next = S_WHOLD;
            end
         end
         S_WHOLD: w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_cnt_dec      = (r_state == S_READ) || (r_state == S_WRITE);
   assign w_be_next      = w_accept ? cpu_be : r_be;
   assign w_rdata_masked = {r_be[1] ? sram_dq[DATA_W-1:HALF] : {HALF{1'b0}},
                            r_be[0] ? sram_dq[HALF-1:0]      : {HALF{1'b0}}};

   // Bus controls are registered from the next state so they line up with
   // the state they belong to and reach the pins glitch-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_be       <= 2'b00;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_ctrl     <= CTRL_IDLE;
         r_drive_en <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= cpu_addr;
            r_be    <= cpu_be;
            r_wdata <= cpu_wdata;
         end
         if (w_sample) begin
            r_rdata <= w_rdata_masked;
         end
         r_ctrl     <= ctrl_for(w_state_next, w_be_next);
         r_drive_en <= (w_state_next == S_WRITE) || (w_state_next == S_WHOLD);
      end
   end

   assign sram_dq   = r_drive_en ? r_wdata : {DATA_W{1'bz}};
   assign sram_addr = r_addr;
   assign sram_ctrl = r_ctrl;
   assign cpu_rdata = r_rdata;
   assign cpu_ready = (r_state == S_DONE);
   assign cpu_busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module  : tb_sram_controller
// Purpose : Scoreboard bench for sram_controller with a behavioural SRAM and
//           word-level reference memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_controller;

   localparam int RD_WAIT = 2;
   localparam int WR_WAIT = 2;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        cpu_req   = 1'b0;
   logic        cpu_we    = 1'b0;
   logic [1:0]  cpu_be    = 2'b00;
   logic [17:0] cpu_addr  = '0;
   logic [15:0] cpu_wdata = '0;
   wire  [15:0] cpu_rdata;
   wire         cpu_ready;
   wire         cpu_busy;
   wire  [17:0] sram_addr;
   wire  [4:0]  sram_ctrl;
   wire  [15:0] sram_dq;

   sram_controller #(
      .ADDR_W  (18),
      .DATA_W  (16),
      .RD_WAIT (RD_WAIT),
      .WR_WAIT (WR_WAIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_be    (cpu_be),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_busy  (cpu_busy),
      .sram_addr (sram_addr),
      .sram_ctrl (sram_ctrl),
      .sram_dq   (sram_dq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural SRAM chip; while deselected the bench holds the bus at zero
   // so any leftover drive from the controller shows up as a wrong value.
   logic [15:0] dev_mem [64];
   logic        tb_en;
   logic [15:0] tb_val;

   always_comb begin
      tb_en  = 1'b0;
      tb_val = 16'h0000;
      if (sram_ctrl[4]) begin
         tb_en = 1'b1;
      end else if (!sram_ctrl[3] && sram_ctrl[2]) begin
         tb_en  = 1'b1;
         tb_val = dev_mem[sram_addr[5:0]];
      end
   end

   assign sram_dq = tb_en ? tb_val : 16'hzzzz;

   always @(posedge clk) begin
      if (!sram_ctrl[4] && !sram_ctrl[2]) begin
         if (!sram_ctrl[1]) dev_mem[sram_addr[5:0]][15:8] <= sram_dq[15:8];
         if (!sram_ctrl[0]) dev_mem[sram_addr[5:0]][7:0]  <= sram_dq[7:0];
      end
   end

   // Reference model and scoreboard queues.
   typedef struct {
      logic [4:0]  ctrl;
      logic [17:0] addr;
      logic [15:0] dq;
   } cyc_t;

   typedef struct {
      logic        chk_rdata;
      logic [15:0] rdata;
      int          accept_cyc;
      int          lat;
   } rsp_t;

   cyc_t        cyc_q[$];
   rsp_t        rsp_q[$];
   logic [15:0] ref_mem [64];
   logic [15:0] last_rdata = 16'h0000;
   int          cyc = 0;

   function automatic logic [15:0] mask(input logic [15:0] d, input logic [1:0] be);
      return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
   endfunction

   always @(negedge clk) begin
      cyc_t e;
      rsp_t r;
      cyc++;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk("ctrl", {27'd0, sram_ctrl}, {27'd0, e.ctrl});
         chk("addr", {14'd0, sram_addr}, {14'd0, e.addr});
         chk("dq",   {16'd0, sram_dq},   {16'd0, e.dq});
         chk("busy", {31'd0, cpu_busy},  32'd1);
      end else begin
         chk("idle_ctrl", {27'd0, sram_ctrl}, 32'h1f);
         chk("idle_busy", {31'd0, cpu_busy},  32'd0);
         chk("idle_dq",   {16'd0, sram_dq},   32'd0);
      end
      if (cpu_ready) begin
         if (rsp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_ready: got 1 expected 0 at %0t", $time);
         end else begin
            r = rsp_q.pop_front();
            chk("latency", cyc - r.accept_cyc, r.lat);
            if (r.chk_rdata) chk("rdata", {16'd0, cpu_rdata}, {16'd0, r.rdata});
         end
      end
   end

   // Called at a falling edge; with chained set the DUT is in DONE and the
   // request stays high through the turnaround IDLE cycle.
   task automatic start(input logic we, input logic [1:0] be, input logic [17:0] a,
                        input logic [15:0] wd, input bit chained);
      cyc_t e;
      rsp_t r;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_be    = be;
      cpu_addr  = a;
      cpu_wdata = wd;
      if (chained) @(posedge clk);
      @(posedge clk);
      r.accept_cyc = cyc;
      r.chk_rdata  = 1'b1;
      r.rdata      = last_rdata;
      if (be == 2'b00) begin
         r.lat = 1;
      end else if (!we) begin
         for (int i = 0; i < RD_WAIT; i++) begin
            e.ctrl = {3'b001, ~be};
            e.addr = a;
            e.dq   = ref_mem[a[5:0]];
            cyc_q.push_back(e);
         end
         last_rdata = mask(ref_mem[a[5:0]], be);
         r.rdata    = last_rdata;
         r.lat      = RD_WAIT + 1;
      end else begin
         for (int i = 0; i < WR_WAIT + 1; i++) begin
            e.ctrl = (i < WR_WAIT) ? {3'b010, ~be} : {3'b011, ~be};
            e.addr = a;
            e.dq   = wd;
            cyc_q.push_back(e);
         end
         if (be[1]) ref_mem[a[5:0]][15:8] = wd[15:8];
         if (be[0]) ref_mem[a[5:0]][7:0]  = wd[7:0];
         r.chk_rdata = 1'b0;
         r.lat       = WR_WAIT + 2;
      end
      e.ctrl = 5'b11111;
      e.addr = a;
      e.dq   = 16'h0000;
      cyc_q.push_back(e);
      rsp_q.push_back(r);
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (cpu_ready) ok = 1'b1;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: got no ready expected ready at %0t", $time);
      end
   endtask

   task automatic access(input logic we, input logic [1:0] be, input logic [17:0] a,
                         input logic [15:0] wd, input bit chained);
      start(we, be, a, wd, chained);
      wait_ready();
   endtask

   task automatic go_idle();
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic abort_after_one(input logic we, input logic [17:0] a, input logic [15:0] wd);
      bit seen;
      start(we, 2'b11, a, wd, 1'b0);
      @(negedge clk);
      #2;
      reset   = 1'b0;
      cpu_req = 1'b0;
      cyc_q.delete();
      rsp_q.delete();
      last_rdata = 16'h0000;
      #1;
      chk("rst_async_ctrl",  {27'd0, sram_ctrl}, 32'h1f);
      chk("rst_async_dq",    {16'd0, sram_dq},   32'd0);
      chk("rst_async_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_async_busy",  {31'd0, cpu_busy},  32'd0);
      #9;
      reset = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (cpu_ready) seen = 1'b1;
      end
      chk("no_ready_after_abort", {31'd0, seen}, 32'd0);
   endtask

   initial begin
      bit chain;
      logic [1:0] be;
      #12;
      chk("rst_ctrl",  {27'd0, sram_ctrl}, 32'h1f);
      chk("rst_addr",  {14'd0, sram_addr}, 32'd0);
      chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_busy",  {31'd0, cpu_busy},  32'd0);
      chk("rst_dq",    {16'd0, sram_dq},   32'd0);
      reset = 1'b1;
      @(negedge clk);

      access(1'b1, 2'b11, 18'h00012, 16'hBEEF, 1'b0); go_idle();
      access(1'b0, 2'b11, 18'h00012, 16'h0000, 1'b0); go_idle();
      access(1'b1, 2'b11, 18'h00020, 16'h1234, 1'b0); go_idle();
      access(1'b0, 2'b01, 18'h00020, 16'h0000, 1'b0); go_idle();
      access(1'b0, 2'b00, 18'h00007, 16'h0000, 1'b0); go_idle();
      access(1'b1, 2'b11, 18'h00030, 16'hCAFE, 1'b0);
      access(1'b0, 2'b10, 18'h00030, 16'h0000, 1'b1);
      access(1'b1, 2'b00, 18'h00031, 16'h5555, 1'b1); go_idle();

      for (int a = 0; a < 64; a++) begin
         chain = (a != 0) && ($urandom_range(0, 1) == 1);
         if (!chain && a != 0) go_idle();
         access(1'b1, 2'b11, 18'(a), 16'($urandom), chain);
      end
      go_idle();

      abort_after_one(1'b1, 18'h0003F, 16'hA5A5);
      abort_after_one(1'b0, 18'h00005, 16'h0000);
      access(1'b0, 2'b00, 18'h00009, 16'h0000, 1'b0); go_idle();

      for (int n = 0; n < 80; n++) begin
         chain = (n != 0) && ($urandom_range(0, 1) == 1);
         if (!chain && n != 0) go_idle();
         be = 2'($urandom_range(0, 3));
         access(1'($urandom_range(0, 1)), be, 18'($urandom_range(0, 62)),
                16'($urandom), chain);
      end
      go_idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", rsp_q.size() + cyc_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side stage directly downstream of the monocycle CPU's data port.
- Turns single-word CPU load/store requests into timed accesses on the board's external asynchronous 256K x 16 SRAM: address bus, 5-bit active-low control bus, bidirectional 16-bit data bus.
- Inserts programmable wait states and returns a one-cycle completion handshake that the CPU uses to stall.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 2, cycles OE_N is held low before read data is sampled (legal range 1..15).
- WR_WAIT, 2, cycles WE_N is held low per write (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  2  byte enables: [1] upper byte, [0] lower byte.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready = 1 after a read.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in any state other than IDLE.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_ctrl  out  5  {ce_n, oe_n, we_n, ub_n, lb_n}, all active-low, registered.
- sram_dq  inout  DATA_W  SRAM data bus.

Behaviour:
- Reset (reset = 0, asynchronous):
  - sram_ctrl = 5'b11111, sram_addr = 0, sram_dq Hi-Z.
  - cpu_rdata = 0, cpu_ready = 0, cpu_busy = 0.
  - FSM goes to IDLE; wait counter = 0.
- FSM states: IDLE, READ, WRITE, WHOLD, DONE.
- IDLE:
  - cpu_req = 1 latches cpu_addr, cpu_we, cpu_be and cpu_wdata into internal registers.
  - cpu_be = 2'b00 goes straight to DONE with no SRAM cycle; cpu_rdata keeps its previous value.
  - Otherwise, cpu_we = 0 goes to READ and cpu_we = 1 goes to WRITE.
- READ:
  - ce_n = 0, oe_n = 0, we_n = 1; ub_n/lb_n = ~be; dq Hi-Z.
  - Lasts exactly RD_WAIT cycles.
  - On the last cycle, sram_dq is sampled into cpu_rdata. Disabled bytes read as 8'h00.
  - Then goes to DONE.
- WRITE:
  - ce_n = 0, oe_n = 1, we_n = 0; ub_n/lb_n = ~be; dq driven with the latched wdata.
  - Lasts exactly WR_WAIT cycles, then goes to WHOLD.
- WHOLD:
  - One cycle with we_n = 1 and ce_n = 0; dq still driven (data hold time).
  - Then goes to DONE.
- DONE:
  - All controls high and dq Hi-Z (bus turnaround).
  - cpu_ready = 1 for exactly this cycle.
  - Next state is IDLE.
- Latency from request-accept edge to the cpu_ready cycle:
  - read: RD_WAIT + 1 cycles;
  - write: WR_WAIT + 2 cycles;
  - be = 00: 1 cycle.
- Back-to-back accesses: a new request is accepted in the IDLE cycle that follows DONE. Minimum of one idle/turnaround cycle between accesses, so dq is never driven by both sides.
- cpu_req while not in IDLE is ignored (not queued). The CPU must hold cpu_req until it sees cpu_ready. A request still high in the IDLE cycle after DONE starts a new access.
- sram_addr stays stable for the whole access and changes only on request accept.
- Wait counter: 4 bits, loaded with WAIT-1 on state entry, decremented each cycle; the state exits when it reaches 0. There is no wrap-around.
- Reset during an access aborts it immediately:
  - controls go high and dq is released in the same instant (asynchronous);
  - no cpu_ready is produced.
- The tristate is implemented as: sram_dq = drive_en ? wdata_q : 'z, with drive_en registered and asserted only in WRITE and WHOLD.

Decomposition:
- Shared package/header (sram_pkg):
  - state encoding constants S_IDLE = 0 … S_DONE = 4;
  - control-bus bit positions CE = 4, OE = 3, WE = 2, UB = 1, LB = 0;
  - CTRL_IDLE = 5'b11111.
- One natural sub-module: sram_wait_counter, a 4-bit load/decrement counter with a zero flag.
- The FSM and the tristate stay in the top module.

Test Plan:
- Reset low for 10 ns mid-run -> sram_ctrl = 5'b11111, sram_dq = z, cpu_ready = 0, cpu_busy = 0, all asynchronously, before the next clk edge.
- Write addr 18'h00012, data 16'hBEEF, be = 11 (RD_WAIT = WR_WAIT = 2):
  - WRITE cycles show ctrl = 5'b01000;
  - WHOLD shows ctrl = 5'b01100 with dq = BEEF still driven;
  - cpu_ready pulses on the 4th cycle after accept.
- Read addr 18'h00012 with the bench SRAM model returning BEEF:
  - ctrl = 5'b00100 for 2 cycles;
  - cpu_rdata = 16'hBEEF while cpu_ready = 1 on the 3rd cycle.
- Byte-lane read, be = 01, model data 16'h1234:
  - ctrl = 5'b00110;
  - cpu_rdata = 16'h0034.
- Request with be = 00 -> cpu_ready the next cycle, sram_ctrl stays 5'b11111, cpu_rdata unchanged.
- cpu_req held high through a write then a read:
  - the second access starts only after one DONE + IDLE gap;
  - sram_dq is never driven while oe_n = 0;
  - a reset asserted mid-READ gives no cpu_ready pulse.
